// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared types, widths and fee helper for the parking controller.
// Revision : 1.0 - initial release
// ============================================================================
package parking_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MOVE_UP   = 3'd1,
        S_ACT       = 3'd2,
        S_MOVE_DOWN = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam int PLATE_W = 16;
    localparam int FEE_W   = 8;
    localparam int FEE_MAX = 255;
    localparam logic [PLATE_W-1:0] EMPTY_PLATE = 16'd0;

    function automatic logic [FEE_W-1:0] fee_calc(input logic [7:0] age,
                                                 input int unsigned per_tick);
        logic [31:0] prod;
        prod = 32'(age) * per_tick;
        return (prod > 32'(FEE_MAX)) ? FEE_W'(FEE_MAX) : prod[FEE_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_slot_search.sv
`default_nettype none
// ============================================================================
// Module   : parking_slot_search
// Purpose  : Combinational lookup of the lowest free slot, plate location and
//            free-slot count over the flattened slot array.
// Revision : 1.0 - initial release
// ============================================================================
module parking_slot_search
    import parking_pkg::*;
#(
    parameter int NUM_FLOORS      = 7,
    parameter int SLOTS_PER_FLOOR = 2,
    parameter int FW              = $clog2(NUM_FLOORS + 1),
    parameter int SW              = (SLOTS_PER_FLOOR > 1) ? $clog2(SLOTS_PER_FLOOR) : 1
) (
    input  logic [NUM_FLOORS*SLOTS_PER_FLOOR*PLATE_W-1:0] i_slots,
    input  logic [NUM_FLOORS-1:0]                         i_flood_mask,
    input  logic [PLATE_W-1:0]                            i_plate,
    output logic [FW-1:0]                                 o_free_floor,
    output logic [SW-1:0]                                 o_free_slot,
    output logic                                          o_free_found,
    output logic [FW-1:0]                                 o_match_floor,
    output logic [SW-1:0]                                 o_match_slot,
    output logic                                          o_match_found,
    output logic                                          o_duplicate,
    output logic [7:0]                                    o_empty_count
);

    logic [PLATE_W-1:0] w_plate_at;

    // Scan from the top down so the last hit written is the lowest floor/slot.
    always_comb begin
        w_plate_at    = EMPTY_PLATE;
        o_free_floor  = '0;
        o_free_slot   = '0;
        o_free_found  = 1'b0;
        o_match_floor = '0;
        o_match_slot  = '0;
        o_match_found = 1'b0;
        o_empty_count = 8'd0;
        for (int f = NUM_FLOORS; f >= 1; f--) begin
            for (int s = SLOTS_PER_FLOOR - 1; s >= 0; s--) begin
                w_plate_at = i_slots[((f-1)*SLOTS_PER_FLOOR + s)*PLATE_W +: PLATE_W];
                if (w_plate_at == EMPTY_PLATE) begin
                    if (!i_flood_mask[f-1]) begin
                        o_free_floor  = FW'(f);
                        o_free_slot   = SW'(s);
                        o_free_found  = 1'b1;
                        o_empty_count = o_empty_count + 8'd1;
                    end
                end else if (w_plate_at == i_plate) begin
                    o_match_floor = FW'(f);
                    o_match_slot  = SW'(s);
                    o_match_found = 1'b1;
                end
            end
        end
        o_duplicate = o_match_found && (i_plate != EMPTY_PLATE);
    end

endmodule
`default_nettype wire

// File: rtl/parking_lot_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_ctrl_param
// Purpose  : Parametrised single-elevator parking controller with slot
//            allocation, saturating fee and flood tracking.
// Revision : 1.0 - initial release
// ============================================================================
module parking_lot_ctrl_param
    import parking_pkg::*;
#(
    parameter int NUM_FLOORS      = 7,
    parameter int SLOTS_PER_FLOOR = 2,
    parameter int TICK_CYCLES     = 4,
    parameter int FEE_PER_TICK    = 10,
    parameter int FW              = $clog2(NUM_FLOORS + 1)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic                                          req_in,
    input  logic [PLATE_W-1:0]                            req_plate,
    input  logic                                          leakage,
    input  logic [FW-1:0]                                 leakage_floor,
    input  logic                                          leakage_clear,
    output logic [FW-1:0]                                 current_floor,
    output logic [PLATE_W-1:0]                            moving,
    output logic [FEE_W-1:0]                              fee,
    output logic                                          done,
    output logic                                          reject,
    output logic [NUM_FLOORS*SLOTS_PER_FLOOR*PLATE_W-1:0] slots,
    output logic [7:0]                                    empty_count,
    output logic                                          full,
    output logic [NUM_FLOORS-1:0]                         flood_mask
);

    localparam int NSLOT = NUM_FLOORS * SLOTS_PER_FLOOR;
    localparam int SW    = (SLOTS_PER_FLOOR > 1) ? $clog2(SLOTS_PER_FLOOR) : 1;
    localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    state_t                         state_q,     state_d;
    logic [FW-1:0]                  floor_q,     floor_d;
    logic [PLATE_W-1:0]             moving_q,    moving_d;
    logic [FEE_W-1:0]               fee_q,       fee_d;
    logic                           done_q,      done_d;
    logic                           reject_q,    reject_d;
    logic [NSLOT-1:0][PLATE_W-1:0]  slots_q,     slots_d;
    logic [NSLOT-1:0][7:0]          age_q,       age_d;
    logic [NUM_FLOORS-1:0]          flood_q,     flood_d;
    logic [TW-1:0]                  tick_q,      tick_d;
    logic [FW-1:0]                  tgt_floor_q, tgt_floor_d;
    logic [IW-1:0]                  tgt_idx_q,   tgt_idx_d;
    logic                           is_entry_q,  is_entry_d;
    logic                           aborted_q,   aborted_d;
    logic [PLATE_W-1:0]             plate_q,     plate_d;

    logic [FW-1:0] w_free_floor;
    logic [SW-1:0] w_free_slot;
    logic          w_free_found;
    logic [FW-1:0] w_match_floor;
    logic [SW-1:0] w_match_slot;
    logic          w_match_found;
    logic          w_dup;
    logic [7:0]    w_empty_count;
    logic          w_wrap;
    logic [IW-1:0] w_free_idx;
    logic [IW-1:0] w_match_idx;

    parking_slot_search #(
        .NUM_FLOORS      (NUM_FLOORS),
        .SLOTS_PER_FLOOR (SLOTS_PER_FLOOR),
        .FW              (FW),
        .SW              (SW)
    ) u_search (
        .i_slots       (slots_q),
        .i_flood_mask  (flood_q),
        .i_plate       (req_plate),
        .o_free_floor  (w_free_floor),
        .o_free_slot   (w_free_slot),
        .o_free_found  (w_free_found),
        .o_match_floor (w_match_floor),
        .o_match_slot  (w_match_slot),
        .o_match_found (w_match_found),
        .o_duplicate   (w_dup),
        .o_empty_count (w_empty_count)
    );

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        moving_d    = moving_q;
        fee_d       = fee_q;
        done_d      = 1'b0;
        reject_d    = 1'b0;
        slots_d     = slots_q;
        age_d       = age_q;
        flood_d     = flood_q;
        tgt_floor_d = tgt_floor_q;
        tgt_idx_d   = tgt_idx_q;
        is_entry_d  = is_entry_q;
        aborted_d   = aborted_q;
        plate_d     = plate_q;

        w_free_idx  = IW'((int'(w_free_floor) - 1) * SLOTS_PER_FLOOR + int'(w_free_slot));
        w_match_idx = IW'((int'(w_match_floor) - 1) * SLOTS_PER_FLOOR + int'(w_match_slot));

        w_wrap = (tick_q == TW'(TICK_CYCLES - 1));
        tick_d = w_wrap ? '0 : tick_q + 1'b1;
        for (int i = 0; i < NSLOT; i++) begin
            if (w_wrap && (slots_q[i] != EMPTY_PLATE) && (age_q[i] != 8'hFF)) begin
                age_d[i] = age_q[i] + 8'd1;
            end
        end

        if (leakage_clear) begin
            flood_d = '0;
        end else if (leakage && (leakage_floor != '0) && (int'(leakage_floor) <= NUM_FLOORS)) begin
            flood_d[leakage_floor - 1'b1] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_plate == EMPTY_PLATE) begin
                        reject_d = 1'b1;
                    end else if (req_in) begin
                        if (!w_free_found || w_dup) begin
                            reject_d = 1'b1;
                        end else begin
                            state_d     = S_MOVE_UP;
                            tgt_floor_d = w_free_floor;
                            tgt_idx_d   = w_free_idx;
                            is_entry_d  = 1'b1;
                            aborted_d   = 1'b0;
                            plate_d     = req_plate;
                            moving_d    = req_plate;
                        end
                    end else begin
                        if (!w_match_found) begin
                            reject_d = 1'b1;
                        end else begin
                            state_d     = S_MOVE_UP;
                            tgt_floor_d = w_match_floor;
                            tgt_idx_d   = w_match_idx;
                            is_entry_d  = 1'b0;
                            aborted_d   = 1'b0;
                            plate_d     = req_plate;
                            moving_d    = EMPTY_PLATE;
                        end
                    end
                end
            end
            S_MOVE_UP: begin
                // Only entries abort; a car is always retrievable from a flooded floor.
                if (is_entry_q && flood_q[tgt_floor_q - 1'b1]) begin
                    aborted_d = 1'b1;
                    state_d   = S_MOVE_DOWN;
                end else begin
                    floor_d = floor_q + 1'b1;
                    if (floor_d == tgt_floor_q) begin
                        state_d = S_ACT;
                    end
                end
            end
            S_ACT: begin
                if (is_entry_q) begin
                    slots_d[tgt_idx_q] = plate_q;
                    moving_d           = EMPTY_PLATE;
                end else begin
                    slots_d[tgt_idx_q] = EMPTY_PLATE;
                    moving_d           = plate_q;
                    fee_d              = fee_calc(age_q[tgt_idx_q], 32'(FEE_PER_TICK));
                end
                age_d[tgt_idx_q] = 8'd0;
                state_d          = S_MOVE_DOWN;
            end
            S_MOVE_DOWN: begin
                if (floor_q <= FW'(1)) begin
                    floor_d  = '0;
                    state_d  = S_DONE;
                    done_d   = !aborted_q;
                    reject_d = aborted_q;
                end else begin
                    floor_d = floor_q - 1'b1;
                end
            end
            S_DONE: begin
                moving_d  = EMPTY_PLATE;
                aborted_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            floor_q     <= '0;
            moving_q    <= EMPTY_PLATE;
            fee_q       <= '0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
            slots_q     <= '0;
            age_q       <= '0;
            flood_q     <= '0;
            tick_q      <= '0;
            tgt_floor_q <= '0;
            tgt_idx_q   <= '0;
            is_entry_q  <= 1'b0;
            aborted_q   <= 1'b0;
            plate_q     <= EMPTY_PLATE;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            moving_q    <= moving_d;
            fee_q       <= fee_d;
            done_q      <= done_d;
            reject_q    <= reject_d;
            slots_q     <= slots_d;
            age_q       <= age_d;
            flood_q     <= flood_d;
            tick_q      <= tick_d;
            tgt_floor_q <= tgt_floor_d;
            tgt_idx_q   <= tgt_idx_d;
            is_entry_q  <= is_entry_d;
            aborted_q   <= aborted_d;
            plate_q     <= plate_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign current_floor = floor_q;
    assign moving        = moving_q;
    assign fee           = fee_q;
    assign done          = done_q;
    assign reject        = reject_q;
    assign slots         = slots_q;
    assign empty_count   = w_empty_count;
    assign full          = (w_empty_count == 8'd0);
    assign flood_mask    = flood_q;

endmodule
`default_nettype wire
